mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Parametrised multi-cycle control sequencer for the RV32 core, replacing the fixed-latency control FSM. It sits between the instruction/decode fields and the datapath write-enables and mux selects. It adds:
- variable-latency memory handshakes with a bus timeout trap;
- a configurable multi-cycle MUL/DIV stall;
- interrupt, ECALL, MRET and illegal-instruction trap sequencing;
- a halt state.

## Interface
Parameters:
- MEM_TIMEOUT, 255, max cycles waited for DataValid before bus-error trap (>=1)
- MULDIV_LAT, 33, cycles spent in MUL/DIV stall (>=1)

Ports:
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- Opcode  in  7  instr[6:0]
- Funct3  in  3  instr[14:12]
- Funct7  in  7  instr[31:25]
- ALUFlag  in  1  branch condition result from ALU
- DataValid  in  1  memory read data valid
- halt  in  1  stop at next instruction boundary
- enintr  in  1  enabled interrupt pending
- ReadReq  out  1  memory read request, level, held until DataValid
- AddrSrcCont  out  1  memory address select: 0 = PC, 1 = ALU result
- WenPC, WenInstr, WenRegfile, WenMem, WenCSR  out  1 each  write enables
- PcTarget  out  1  in WB: 1 = load branch/jump target, 0 = PC+4
- MuldivStart  out  1  one-cycle start pulse to MUL/DIV unit
- ECALL, MRET, INTR, BusErr, Illegal  out  1 each  one-cycle cause pulses
- State  out  4  current state code (debug)

## Operation
- States and encodings: FETCH=0, FWAIT=1, DECODE=2, EXEC=3, MDWAIT=4, MEMRD=5, MWAIT=6, MEMWR=7, WB=8, TRAP=9, HALT=10.
- Outputs are combinational from state and inputs.
- FETCH: halt -> HALT; else enintr -> TRAP (INTR=1); else ReadReq=1, AddrSrcCont=0 -> FWAIT.
- FWAIT: ReadReq=1, AddrSrcCont=0.
  - DataValid -> WenInstr=1 -> DECODE.
  - Wait counter reaches MEM_TIMEOUT -> TRAP (BusErr=1).
- DECODE, opcode 1110011 with Funct3=000:
  - Funct7=0011000 (MRET) -> MRET=1, WenPC=1 -> FETCH.
  - Otherwise (ECALL) -> ECALL=1 -> TRAP.
- DECODE, unsupported opcode -> Illegal=1 -> TRAP.
- DECODE, all other opcodes -> EXEC.
- EXEC dispatch:
  - load 0000011 -> MEMRD.
  - store 0100011 -> MEMWR.
  - OP 0110011 with Funct7=0000001 -> MuldivStart=1 -> MDWAIT.
  - everything else -> WB.
  - Branch/JAL/JALR: latch pc_sel = JAL|JALR|(branch & ALUFlag).
- MDWAIT: held exactly MULDIV_LAT cycles, then WB.
- MEMRD: ReadReq=1, AddrSrcCont=1 -> MWAIT.
- MWAIT: same handshake and timeout rules as FWAIT; DataValid -> WB.
- MEMWR: WenMem=1, AddrSrcCont=1, posted write -> WB.
- WB:
  - WenPC=1, PcTarget=pc_sel.
  - WenRegfile=1 except store/branch.
  - CSR instructions (1110011, Funct3!=0) assert WenCSR=1.
  - -> FETCH.
- TRAP: WenPC=1, WenCSR=1 for one cycle -> FETCH.
- HALT: all enables 0; halt=0 -> FETCH.
- Wait counter width is $clog2(MEM_TIMEOUT+1). It clears on entry to FWAIT/MWAIT; the MDWAIT counter clears on entry.

## Timing
- Reset: State=FETCH, counters=0, pc_sel=0, every output 0 except the FETCH decode (ReadReq=1 once reset deasserts).
- Reset asserted mid-operation: FETCH on the next edge, ReadReq drops in the same cycle, counters cleared.
- Zero-wait ALU instruction (DataValid the cycle after FETCH): 5 cycles. Load: 7 cycles. MUL/DIV: 5 + MULDIV_LAT cycles.
- DataValid and timeout in the same cycle: DataValid wins, no BusErr.
- DataValid outside FWAIT/MWAIT is ignored.
- halt and enintr together in FETCH: halt wins; the interrupt is taken after the halt is released.
- halt/enintr are sampled only in FETCH; an instruction in flight always completes.
- Cause pulses last exactly one cycle.

## Configuration
- MULDIV_EN defined: M-extension sequencing (MuldivStart, MDWAIT) as above.
- MULDIV_EN undefined: OP with Funct7=0000001 is illegal (DECODE -> Illegal=1 -> TRAP). MDWAIT logic and its counter are absent. MuldivStart is tied to 0.

## Test plan
- ADD, DataValid one cycle after ReadReq -> states 0,1,2,3,8. WenRegfile=1 and WenPC=1 in cycle 5, PcTarget=0.
- BEQ with ALUFlag=1, then with ALUFlag=0 -> WB has PcTarget=1 then 0. WenRegfile=0 both times.
- LW, DataValid withheld MEM_TIMEOUT=4 cycles in MWAIT -> BusErr=1, TRAP, WenCSR=1, back to FETCH. Repeat with DataValid on cycle 4 -> WB, no BusErr.
- MUL with MULDIV_LAT=3 -> MuldivStart pulse in EXEC, exactly 3 MDWAIT cycles, WB. Without MULDIV_EN -> Illegal=1 and TRAP.
- halt=1 and enintr=1 at FETCH -> HALT. Release halt -> FETCH -> TRAP with INTR=1.
- Reset asserted in FWAIT with ReadReq=1 -> next cycle State=0, counters 0, no WenInstr.

Source files
------------

// File: rtl/mc_sequencer_if.sv
// Bundle of decode fields, datapath handshakes and control strobes between
// the multi-cycle sequencer (master) and the datapath (slave).
interface mc_sequencer_if;
    // decode fields and datapath status
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       ALUFlag;
    logic       DataValid;
    logic       halt;
    logic       enintr;
    // control outputs
    logic       ReadReq;
    logic       AddrSrcCont;
    logic       WenPC;
    logic       WenInstr;
    logic       WenRegfile;
    logic       WenMem;
    logic       WenCSR;
    logic       PcTarget;
    logic       MuldivStart;
    logic       ECALL;
    logic       MRET;
    logic       INTR;
    logic       BusErr;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Opcode, Funct3, Funct7, ALUFlag, DataValid, halt, enintr,
        output ReadReq, AddrSrcCont, WenPC, WenInstr, WenRegfile, WenMem, WenCSR,
               PcTarget, MuldivStart, ECALL, MRET, INTR, BusErr, Illegal, State
    );

    modport slave (
        output Opcode, Funct3, Funct7, ALUFlag, DataValid, halt, enintr,
        input  ReadReq, AddrSrcCont, WenPC, WenInstr, WenRegfile, WenMem, WenCSR,
               PcTarget, MuldivStart, ECALL, MRET, INTR, BusErr, Illegal, State
    );
endinterface

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for the RV32 core.
// Handles variable-latency memory reads with a bus timeout trap, traps for
// interrupts / ECALL / illegal opcodes, MRET, and a halt state.
// Optional feature: define MULDIV_EN to sequence M-extension instructions
// (MuldivStart pulse plus a MULDIV_LAT-cycle stall). Without it, OP-class
// instructions with Funct7=0000001 trap as illegal and MuldivStart is 0.
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int MULDIV_LAT  = 33
) (
    input  logic           clk,
    input  logic           reset,
    mc_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_FWAIT  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MDWAIT = 4'd4,
        S_MEMRD  = 4'd5,
        S_MWAIT  = 4'd6,
        S_MEMWR  = 4'd7,
        S_WB     = 4'd8,
        S_TRAP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [6:0] F7_MRET   = 7'b0011000;

    // Wait counter counts completed cycles in FWAIT/MWAIT; the trap fires in
    // the MEM_TIMEOUT-th waiting cycle unless DataValid arrives in it.
    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    // Reject meaningless parameterisations at elaboration.
    if (MEM_TIMEOUT < 1 || MULDIV_LAT < 1) begin : g_bad_params
        $error("mc_sequencer: MEM_TIMEOUT and MULDIV_LAT must both be >= 1");
    end

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              pc_sel_q, pc_sel_d;

`ifdef MULDIV_EN
    localparam int                MCNT_W    = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MULDIV_LAT - 1);
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic              muldiv_start;
`endif

    logic is_muldiv, is_sys_priv, is_supported, is_store, is_branch, is_csr;
    logic read_req, addr_src, wen_pc, wen_instr, wen_regfile, wen_mem, wen_csr;
    logic pc_target, ecall_p, mret_p, intr_p, bus_err_p, illegal_p;

    // Instruction classification from the latched decode fields.
    always_comb begin
        is_muldiv   = (bus.Opcode == OP_OP) && (bus.Funct7 == F7_MULDIV);
        is_sys_priv = (bus.Opcode == OP_SYSTEM) && (bus.Funct3 == 3'b000);
        is_csr      = (bus.Opcode == OP_SYSTEM) && (bus.Funct3 != 3'b000);
        is_store    = (bus.Opcode == OP_STORE);
        is_branch   = (bus.Opcode == OP_BRANCH);
        case (bus.Opcode)
            OP_LOAD, OP_FENCE, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: is_supported = 1'b1;
            default:                                        is_supported = 1'b0;
        endcase
`ifndef MULDIV_EN
        if (is_muldiv) begin
            is_supported = 1'b0;
        end
`endif
    end

    // Next-state and control decode; every strobe defaults low.
    always_comb begin
        state_d     = state_q;
        pc_sel_d    = pc_sel_q;
        read_req    = 1'b0;
        addr_src    = 1'b0;
        wen_pc      = 1'b0;
        wen_instr   = 1'b0;
        wen_regfile = 1'b0;
        wen_mem     = 1'b0;
        wen_csr     = 1'b0;
        pc_target   = 1'b0;
        ecall_p     = 1'b0;
        mret_p      = 1'b0;
        intr_p      = 1'b0;
        bus_err_p   = 1'b0;
        illegal_p   = 1'b0;
`ifdef MULDIV_EN
        muldiv_start = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                if (bus.halt) begin
                    state_d = S_HALT;
                end else if (bus.enintr) begin
                    intr_p  = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    read_req = 1'b1;
                    state_d  = S_FWAIT;
                end
            end
            S_FWAIT: begin
                read_req = 1'b1;
                if (bus.DataValid) begin
                    wen_instr = 1'b1;
                    state_d   = S_DECODE;
                end else if (wcnt_q == WCNT_LAST) begin
                    bus_err_p = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                if (is_sys_priv) begin
                    if (bus.Funct7 == F7_MRET) begin
                        mret_p  = 1'b1;
                        wen_pc  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        ecall_p = 1'b1;
                        state_d = S_TRAP;
                    end
                end else if (!is_supported) begin
                    illegal_p = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Branch decision is captured here because ALUFlag is only
                // meaningful while the comparison is on the ALU.
                pc_sel_d = (bus.Opcode == OP_JAL) || (bus.Opcode == OP_JALR) ||
                           (is_branch && bus.ALUFlag);
                if (bus.Opcode == OP_LOAD) begin
                    state_d = S_MEMRD;
                end else if (is_store) begin
                    state_d = S_MEMWR;
`ifdef MULDIV_EN
                end else if (is_muldiv) begin
                    muldiv_start = 1'b1;
                    state_d      = S_MDWAIT;
`endif
                end else begin
                    state_d = S_WB;
                end
            end
`ifdef MULDIV_EN
            S_MDWAIT: begin
                if (mcnt_q == MCNT_LAST) begin
                    state_d = S_WB;
                end
            end
`endif
            S_MEMRD: begin
                read_req = 1'b1;
                addr_src = 1'b1;
                state_d  = S_MWAIT;
            end
            S_MWAIT: begin
                read_req = 1'b1;
                addr_src = 1'b1;
                if (bus.DataValid) begin
                    state_d = S_WB;
                end else if (wcnt_q == WCNT_LAST) begin
                    bus_err_p = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_MEMWR: begin
                wen_mem  = 1'b1;
                addr_src = 1'b1;
                state_d  = S_WB;
            end
            S_WB: begin
                wen_pc      = 1'b1;
                pc_target   = pc_sel_q;
                wen_regfile = !(is_store || is_branch);
                wen_csr     = is_csr;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                wen_pc  = 1'b1;
                wen_csr = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (!bus.halt) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Counter runs only while staying in a wait state, so it is zero on entry.
        wcnt_d = '0;
        if ((state_q == S_FWAIT || state_q == S_MWAIT) && state_d == state_q) begin
            wcnt_d = wcnt_q + 1'b1;
        end
`ifdef MULDIV_EN
        mcnt_d = '0;
        if (state_q == S_MDWAIT && state_d == S_MDWAIT) begin
            mcnt_d = mcnt_q + 1'b1;
        end
`endif
    end

    // State, wait counter and branch-select registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wcnt_q   <= '0;
            pc_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            pc_sel_q <= pc_sel_d;
        end
    end

`ifdef MULDIV_EN
    // MUL/DIV stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcnt_q <= '0;
        end else begin
            mcnt_q <= mcnt_d;
        end
    end
    assign bus.MuldivStart = muldiv_start & ~reset;
`else
    assign bus.MuldivStart = 1'b0;
`endif

    // Strobes are suppressed while reset is held so nothing fires mid-reset.
    assign bus.ReadReq     = read_req    & ~reset;
    assign bus.AddrSrcCont = addr_src    & ~reset;
    assign bus.WenPC       = wen_pc      & ~reset;
    assign bus.WenInstr    = wen_instr   & ~reset;
    assign bus.WenRegfile  = wen_regfile & ~reset;
    assign bus.WenMem      = wen_mem     & ~reset;
    assign bus.WenCSR      = wen_csr     & ~reset;
    assign bus.PcTarget    = pc_target   & ~reset;
    assign bus.ECALL       = ecall_p     & ~reset;
    assign bus.MRET        = mret_p      & ~reset;
    assign bus.INTR        = intr_p      & ~reset;
    assign bus.BusErr      = bus_err_p   & ~reset;
    assign bus.Illegal     = illegal_p   & ~reset;
    assign bus.State       = state_q;
endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: an instruction-level model expands each transaction
// into its expected per-cycle trace; a negedge process compares the DUT to it.
`timescale 1ns/1ps
module tb_mc_sequencer;
    localparam int TO  = 4;
    localparam int LAT = 3;
`ifdef MULDIV_EN
    localparam bit MULDIV_ON = 1'b1;
`else
    localparam bit MULDIV_ON = 1'b0;
`endif

    localparam logic [3:0] ST_FETCH = 4'd0, ST_FWAIT = 4'd1, ST_DECODE = 4'd2, ST_EXEC = 4'd3,
                           ST_MDWAIT = 4'd4, ST_MEMRD = 4'd5, ST_MWAIT = 4'd6, ST_MEMWR = 4'd7,
                           ST_WB = 4'd8, ST_TRAP = 4'd9, ST_HALT = 4'd10;

    localparam logic [6:0] LOAD = 7'b0000011, FENCE = 7'b0001111, OPIMM = 7'b0010011,
                           AUIPC = 7'b0010111, STORE = 7'b0100011, OP = 7'b0110011,
                           LUI = 7'b0110111, BRANCH = 7'b1100011, JALR = 7'b1100111,
                           JAL = 7'b1101111, SYSTEM = 7'b1110011;

    // bit positions of the output vector
    localparam int B_RR = 13, B_AS = 12, B_WPC = 11, B_WI = 10, B_WRF = 9, B_WMEM = 8,
                   B_WCSR = 7, B_PCT = 6, B_MDS = 5, B_ECALL = 4, B_MRET = 3, B_INTR = 2,
                   B_BE = 1, B_ILL = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_sequencer_if bus();

    mc_sequencer #(.MEM_TIMEOUT(TO), .MULDIV_LAT(LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          txn = 0;
    logic        halt_v = 1'b0;
    logic        intr_v = 1'b0;
    logic        flag_v = 1'b0;
    string       cur_name = "reset";
    logic [17:0] exp_q[$];
    string       name_q[$];

    // Single compare process: every cycle with a queued expectation is checked.
    always @(negedge clk) begin : cmp
        logic [17:0] e;
        logic [17:0] a;
        string       nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {bus.State, bus.ReadReq, bus.AddrSrcCont, bus.WenPC, bus.WenInstr,
                  bus.WenRegfile, bus.WenMem, bus.WenCSR, bus.PcTarget, bus.MuldivStart,
                  bus.ECALL, bus.MRET, bus.INTR, bus.BusErr, bus.Illegal};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s t=%0t state act=%0d req=%0d outs act=%b req=%b",
                         nm, $time, a[17:14], e[17:14], a[13:0], e[13:0]);
            end
        end
    end

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [13:0] ob(input int b);
        logic [13:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic bit legal(input logic [6:0] op, input logic [6:0] f7);
        bit known;
        known = (op == LOAD) || (op == FENCE) || (op == OPIMM) || (op == AUIPC) ||
                (op == STORE) || (op == OP) || (op == LUI) || (op == BRANCH) ||
                (op == JALR) || (op == JAL) || (op == SYSTEM);
        if (!MULDIV_ON && op == OP && f7 == 7'b0000001) known = 1'b0;
        return known;
    endfunction

    // One clock of stimulus plus the output vector the model requires for it.
    task automatic step(input logic dv, input logic [3:0] st, input logic [13:0] o);
        bus.DataValid = dv;
        if (st == ST_FETCH || st == ST_HALT) begin
            bus.halt   = halt_v;
            bus.enintr = intr_v;
        end else begin
            bus.halt   = rnd();
            bus.enintr = rnd();
        end
        bus.ALUFlag = (st == ST_EXEC) ? flag_v : rnd();
        exp_q.push_back({st, o});
        name_q.push_back(cur_name);
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic trap();
        step(rnd(), ST_TRAP, ob(B_WPC) | ob(B_WCSR));
    endtask

    // Memory wait: DataValid appears after 'delay' idle cycles; the wait gives
    // up in its TO-th cycle, where a simultaneous DataValid still wins.
    task automatic mem_wait(input logic [3:0] st, input logic addr, input int delay, output bit ok);
        logic [13:0] o;
        ok = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            o = ob(B_RR) | (addr ? ob(B_AS) : 14'd0);
            if (k == delay + 1) begin
                if (st == ST_FWAIT) o = o | ob(B_WI);
                step(1'b1, st, o);
                ok = 1'b1;
                return;
            end
            if (k == TO) begin
                step(1'b0, st, o | ob(B_BE));
                trap();
                return;
            end
            step(1'b0, st, o);
        end
    endtask

    task automatic instr_body(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic flag, input int fd, input int md);
        bit          ok;
        bit          mul;
        logic [13:0] o;
        bus.Opcode = op;
        bus.Funct3 = f3;
        bus.Funct7 = f7;
        flag_v = flag;
        halt_v = 1'b0;
        intr_v = 1'b0;
        step(rnd(), ST_FETCH, ob(B_RR));
        mem_wait(ST_FWAIT, 1'b0, fd, ok);
        if (!ok) return;
        if (op == SYSTEM && f3 == 3'b000) begin
            if (f7 == 7'b0011000) begin
                step(rnd(), ST_DECODE, ob(B_MRET) | ob(B_WPC));
            end else begin
                step(rnd(), ST_DECODE, ob(B_ECALL));
                trap();
            end
            return;
        end
        if (!legal(op, f7)) begin
            step(rnd(), ST_DECODE, ob(B_ILL));
            trap();
            return;
        end
        step(rnd(), ST_DECODE, 14'd0);
        mul = MULDIV_ON && op == OP && f7 == 7'b0000001;
        step(rnd(), ST_EXEC, mul ? ob(B_MDS) : 14'd0);
        if (op == LOAD) begin
            step(rnd(), ST_MEMRD, ob(B_RR) | ob(B_AS));
            mem_wait(ST_MWAIT, 1'b1, md, ok);
            if (!ok) return;
        end else if (op == STORE) begin
            step(rnd(), ST_MEMWR, ob(B_WMEM) | ob(B_AS));
        end else if (mul) begin
            for (int i = 0; i < LAT; i++) step(rnd(), ST_MDWAIT, 14'd0);
        end
        o = ob(B_WPC);
        if (op == JAL || op == JALR || (op == BRANCH && flag)) o = o | ob(B_PCT);
        if (op != STORE && op != BRANCH) o = o | ob(B_WRF);
        if (op == SYSTEM && f3 != 3'b000) o = o | ob(B_WCSR);
        step(rnd(), ST_WB, o);
    endtask

    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic flag, input int fd, input int md,
                             output int len);
        int start;
        start = cyc_cnt;
        cur_name = nm;
        instr_body(op, f3, f7, flag, fd, md);
        len = cyc_cnt - start;
        txn++;
        $display("txn %0d %s op=%b f3=%b f7=%b flag=%0d fd=%0d md=%0d cycles=%0d",
                 txn, nm, op, f3, f7, flag, fd, md, len);
    endtask

    // halt and/or interrupt presented at an instruction boundary
    task automatic fetch_event(input logic h, input logic i, input int hold);
        cur_name = "fetch_evt";
        halt_v = h;
        intr_v = i;
        if (h) begin
            step(rnd(), ST_FETCH, 14'd0);
            for (int k = 0; k < hold; k++) step(rnd(), ST_HALT, 14'd0);
            halt_v = 1'b0;
            step(rnd(), ST_HALT, 14'd0);
        end
        if (i) begin
            step(rnd(), ST_FETCH, ob(B_INTR));
            trap();
        end
        intr_v = 1'b0;
        txn++;
        $display("txn %0d fetch_evt halt=%0d intr=%0d hold=%0d", txn, h, i, hold);
    endtask

    task automatic check_len(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL len_%s act=%0d req=%0d", nm, got, req);
        end
    endtask

    initial begin : main
        logic [6:0] ops[14];
        int         len;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        ops = '{LOAD, FENCE, OPIMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM,
                7'b0000000, 7'b1111111, 7'b1010011};
        bus.Opcode = '0; bus.Funct3 = '0; bus.Funct7 = '0;
        bus.ALUFlag = 1'b0; bus.DataValid = 1'b0; bus.halt = 1'b0; bus.enintr = 1'b0;

        // reset: FETCH with every strobe held low
        @(posedge clk);
        #1;
        step(1'b1, ST_FETCH, 14'd0);
        reset = 1'b0;

        run_instr("add", OP, 3'b000, 7'b0000000, 1'b0, 0, 0, len);       check_len("add", len, 5);
        run_instr("beq_t", BRANCH, 3'b000, 7'b0, 1'b1, 0, 0, len);        check_len("beq_t", len, 5);
        run_instr("beq_nt", BRANCH, 3'b000, 7'b0, 1'b0, 0, 0, len);       check_len("beq_nt", len, 5);
        run_instr("lw", LOAD, 3'b010, 7'b0, 1'b0, 0, 0, len);             check_len("lw", len, 7);
        run_instr("lw_to", LOAD, 3'b010, 7'b0, 1'b0, 0, TO, len);         check_len("lw_to", len, 10);
        run_instr("lw_edge", LOAD, 3'b010, 7'b0, 1'b0, 0, TO - 1, len);   check_len("lw_edge", len, 10);
        run_instr("mul", OP, 3'b000, 7'b0000001, 1'b0, 0, 0, len);
        check_len("mul", len, MULDIV_ON ? 5 + LAT : 4);
        run_instr("sw", STORE, 3'b010, 7'b0, 1'b0, 0, 0, len);            check_len("sw", len, 6);
        run_instr("jal", JAL, 3'b000, 7'b0, 1'b0, 1, 0, len);             check_len("jal", len, 6);
        run_instr("ecall", SYSTEM, 3'b000, 7'b0, 1'b0, 0, 0, len);        check_len("ecall", len, 4);
        run_instr("mret", SYSTEM, 3'b000, 7'b0011000, 1'b0, 0, 0, len);   check_len("mret", len, 3);
        run_instr("csrrw", SYSTEM, 3'b001, 7'b0, 1'b0, 0, 0, len);        check_len("csrrw", len, 5);
        run_instr("illegal", 7'b0000000, 3'b000, 7'b0, 1'b0, 0, 0, len);  check_len("illegal", len, 4);
        run_instr("fetch_to", OP, 3'b000, 7'b0, 1'b0, TO, 0, len);        check_len("fetch_to", len, 6);
        fetch_event(1'b1, 1'b1, 2);

        // reset asserted while waiting for the instruction fetch
        cur_name = "rst_mid";
        bus.Opcode = OP; bus.Funct3 = 3'b000; bus.Funct7 = 7'b0;
        step(rnd(), ST_FETCH, ob(B_RR));
        step(1'b0, ST_FWAIT, ob(B_RR));
        reset = 1'b1;
        step(1'b1, ST_FWAIT, 14'd0);
        reset = 1'b0;
        run_instr("after_rst", OP, 3'b000, 7'b0, 1'b0, TO - 1, 0, len);   check_len("after_rst", len, 8);

        // randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic h;
                h = rnd();
                fetch_event(h, h ? rnd() : 1'b1, int'($urandom_range(0, 3)));
            end
            op = ops[$urandom_range(0, 13)];
            f3 = 3'($urandom_range(0, 7));
            if (op == SYSTEM && rnd()) f3 = 3'b000;
            case ($urandom_range(0, 3))
                0:       f7 = 7'b0000000;
                1:       f7 = 7'b0000001;
                2:       f7 = 7'b0011000;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            run_instr("rand", op, f3, f7, rnd(), int'($urandom_range(0, TO + 1)),
                      int'($urandom_range(0, TO + 1)), len);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
